// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Holds the FSM/owner encodings and default bus widths.
package mem_bus_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam logic [DW_DEF/8-1:0] BE_ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of data wins taken while fetch was waiting; clear has priority.
// Updates one cycle after clr/inc; sat is a registered-state decode, no backpressure.
module starve_counter #(
  parameter int MAX = 4,
  localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  localparam logic [CW-1:0] MAX_V = CW'(MAX);

  logic [CW-1:0] cnt;

  assign sat = (cnt == MAX_V);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between fetch and data ports, one transaction outstanding.
// Request to response >= 3 cycles; requesters hold until gnt, one idle bubble between transactions.
module mem_port_arbiter
  import mem_bus_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            proto_err
);

  state_t state;
  owner_t owner;
  logic   arb;
  logic   pick_if;
  logic   cnt_inc;
  logic   cnt_clr;
  logic   starve_sat;

  assign arb     = (state == IDLE) && (if_req || d_req);
  assign pick_if = if_req && (!d_req || starve_sat);
  assign cnt_inc = arb && !pick_if && if_req;
  assign cnt_clr = arb && !cnt_inc;

  starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .sat (starve_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      proto_err <= 1'b0;
    end else begin
      // Responses with nothing outstanding are never routed, only flagged.
      if (mem_rvalid && (state != WAIT_RSP)) begin
        proto_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (arb) begin
            owner     <= pick_if ? OWN_IF : OWN_D;
            mem_req   <= 1'b1;
            mem_we    <= pick_if ? 1'b0 : d_we;
            mem_be    <= pick_if ? {(DW/8){1'b1}} : d_be;
            mem_addr  <= pick_if ? if_addr : d_addr;
            mem_wdata <= pick_if ? '0 : d_wdata;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid) begin
            owner <= OWN_NONE;
            state <= IDLE;
          end
        end
        default: begin
          owner   <= OWN_NONE;
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign if_gnt    = (state == REQ) && mem_ready && (owner == OWN_IF);
  assign d_gnt     = (state == REQ) && mem_ready && (owner == OWN_D);
  assign if_rvalid = (state == WAIT_RSP) && mem_rvalid && (owner == OWN_IF);
  assign d_rvalid  = (state == WAIT_RSP) && mem_rvalid && (owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  // mem_we still holds the owner's store flag throughout WAIT_RSP.
  assign d_rdata   = (d_rvalid && !mem_we) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: drivers, memory model and a negedge scoreboard.
// The reference model arbitrates whole transactions from the priority/starvation rules.
module tb_mem_port_arbiter;
  import mem_bus_pkg::*;

  localparam int STARVE_MAX = 4;

  logic        clk, rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid, proto_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // Memory model controls: fixed delays when >= 0, random otherwise.
  bit          mem_en = 0, mon_en = 0, fix_rd_en = 0;
  int          rdy_fix = -1, rsp_fix = -1;
  logic [31:0] fix_rd = 0;
  logic [31:0] rsp_q[$];
  bit          win_log[$];

  initial begin
    bit seen, pend;
    int wwait, rwait;
    seen = 0; pend = 0; wwait = 0; rwait = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
      if (!mem_en) begin
        seen = 0; pend = 0;
      end else if (pend) begin
        if (rwait == 0) begin
          mem_rvalid = 1;
          mem_rdata = fix_rd_en ? fix_rd : $urandom;
          rsp_q.push_back(mem_rdata);
          pend = 0;
        end else rwait--;
      end else if (mem_req) begin
        if (!seen) begin
          seen = 1;
          wwait = (rdy_fix >= 0) ? rdy_fix : $urandom_range(0, 3);
        end
        if (wwait == 0) begin
          mem_ready = 1; pend = 1; seen = 0;
          rwait = (rsp_fix >= 0) ? rsp_fix : $urandom_range(0, 4);
        end else wwait--;
      end
    end
  end

  // Transaction-level reference: phase 0 idle, 1 request on bus, 2 awaiting response.
  int          ph = 0, ph_n, streak = 0;
  bit          e_if, e_we;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata, exp_rd;

  always @(negedge clk) begin
    if (mon_en) begin
      ph_n = ph;
      chk("proto_err_clear", proto_err, 0);
      case (ph)
        0: begin
          chk("idle_mem_req", mem_req, 0);
          chk("idle_gnt", {if_gnt, d_gnt}, 0);
          chk("idle_rvalid", {if_rvalid, d_rvalid}, 0);
          if (if_req || d_req) begin
            e_if = (if_req && d_req) ? (streak == STARVE_MAX) : if_req;
            streak = (!e_if && if_req) ? ((streak < STARVE_MAX) ? streak + 1 : STARVE_MAX) : 0;
            e_addr  = e_if ? if_addr : d_addr;
            e_we    = e_if ? 1'b0 : d_we;
            e_be    = e_if ? BE_ALL_ONES : d_be;
            e_wdata = e_if ? 32'h0 : d_wdata;
            win_log.push_back(e_if);
            ph_n = 1;
          end
        end
        1: begin
          chk("req_mem_req", mem_req, 1);
          chk("req_addr", mem_addr, e_addr);
          chk("req_we", mem_we, e_we);
          chk("req_be", mem_be, e_be);
          chk("req_wdata", mem_wdata, e_wdata);
          chk("req_rvalid", {if_rvalid, d_rvalid}, 0);
          if (mem_ready) begin
            chk("if_gnt", if_gnt, e_if);
            chk("d_gnt", d_gnt, !e_if);
            ph_n = 2;
          end else chk("gnt_early", {if_gnt, d_gnt}, 0);
        end
        default: begin
          chk("wait_mem_req", mem_req, 0);
          chk("wait_gnt", {if_gnt, d_gnt}, 0);
          if (mem_rvalid) begin
            chk("rsp_expected", rsp_q.size() != 0, 1);
            exp_rd = (rsp_q.size() != 0) ? rsp_q.pop_front() : 32'h0;
            if (e_if) begin
              chk("if_rvalid", if_rvalid, 1);
              chk("if_rdata", if_rdata, exp_rd);
              chk("d_rvalid_other", d_rvalid, 0);
              chk("d_rdata_other", d_rdata, 0);
            end else begin
              chk("d_rvalid", d_rvalid, 1);
              chk("d_rdata", d_rdata, e_we ? 32'h0 : exp_rd);
              chk("if_rvalid_other", if_rvalid, 0);
              chk("if_rdata_other", if_rdata, 0);
            end
            ph_n = 0;
          end else chk("wait_rvalid", {if_rvalid, d_rvalid}, 0);
        end
      endcase
      ph = ph_n;
    end
  end

  // Drivers are entered and left #1 after a rising edge.
  task automatic drv_if_one(input logic [31:0] a);
    bit got = 0;
    if_req = 1; if_addr = a;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = if_gnt;
    end
    chk("if_gnt_timeout", got, 1);
    @(posedge clk); #1;
    if_req = 0;
  endtask

  task automatic drv_d_one(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    bit got = 0;
    d_req = 1; d_we = we; d_be = be; d_addr = a; d_wdata = wd;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = d_gnt;
    end
    chk("d_gnt_timeout", got, 1);
    @(posedge clk); #1;
    d_req = 0;
  endtask

  task automatic drv_if_loop(input int n, input int gmax);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gmax)) begin @(posedge clk); #1; end
      drv_if_one($urandom & 32'hFFFF_FFFC);
    end
  endtask

  task automatic drv_d_loop(input int n, input int gmax);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gmax)) begin @(posedge clk); #1; end
      drv_d_one($urandom_range(0, 1), 4'($urandom), $urandom, $urandom);
    end
  endtask

  task automatic settle();
    repeat (30) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    mon_en = 0; mem_en = 0; if_req = 0; d_req = 0;
    @(negedge clk);
    rst = 0;
    ph = 0; streak = 0; rsp_q.delete(); win_log.delete();
    repeat (2) @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    mem_en = 1; mon_en = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 0; if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ctrl", {mem_we, mem_be, if_gnt, d_gnt, if_rvalid, d_rvalid, proto_err}, 0);
    chk("rst_bus", mem_addr | mem_wdata | if_rdata | d_rdata, 0);

    // Reset asserted while a fetch sits in REQ.
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h10;
    repeat (2) @(negedge clk);
    chk("mid_req_mem_req", mem_req, 1);
    chk("mid_req_addr", mem_addr, 32'h10);
    #2 rst = 0; mem_ready = 1; mem_rvalid = 1;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_ctrl", {mem_we, mem_be, if_gnt, d_gnt, if_rvalid, d_rvalid, proto_err}, 0);
    chk("arst_bus", mem_addr | mem_wdata | if_rdata | d_rdata, 0);
    mem_ready = 0; mem_rvalid = 0; if_req = 0; if_addr = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("post_rst_mem_req", mem_req, 0);
    chk("post_rst_proto", proto_err, 0);
    mem_rvalid = 1;
    #1 chk("stray_not_routed", {if_rvalid, d_rvalid}, 0);
    @(negedge clk);
    chk("stray_proto_set", proto_err, 1);
    @(negedge clk);
    chk("proto_sticky", proto_err, 1);
    do_reset();

    // Single fetch and delayed-ready store with fixed memory timing.
    rdy_fix = 0; rsp_fix = 1; fix_rd_en = 1; fix_rd = 32'h0040_0093;
    drv_if_one(32'h0000_0004);
    settle();
    rdy_fix = 3; rsp_fix = 0; fix_rd = 32'h1234_5678;
    drv_d_one(1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
    settle();

    // Simultaneous requests: data first, fetch next.
    rdy_fix = -1; rsp_fix = -1; fix_rd_en = 0;
    do_reset();
    fork
      drv_if_one(32'h200);
      drv_d_one(1'b0, 4'hF, 32'h300, 32'h0);
    join
    settle();
    chk("simul_grants", win_log.size(), 2);
    if (win_log.size() >= 2) begin
      chk("simul_first_d", win_log[0], 0);
      chk("simul_then_if", win_log[1], 1);
    end

    // Continuous contention: D,D,D,D,IF repeating.
    do_reset();
    fork
      drv_if_loop(12, 0);
      drv_d_loop(12, 0);
    join
    settle();
    chk("starve_enough", win_log.size() >= 10, 1);
    for (int k = 0; k < 10 && k < win_log.size(); k++)
      chk($sformatf("starve_order_%0d", k), win_log[k], (k % 5) == 4);

    // Long response stall with a new data request waiting.
    rdy_fix = 0; rsp_fix = 10;
    drv_d_loop(3, 0);
    settle();

    // Random traffic.
    rdy_fix = -1; rsp_fix = -1;
    fork
      drv_if_loop(60, 3);
      drv_d_loop(60, 3);
    join
    settle();
    chk("all_rsp_consumed", rsp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between the CPU instruction-fetch port and the load/store data port.
- Allows one outstanding transaction. Data has priority, with an anti-starvation counter that guarantees fetch progress.
- Sits between the cpu_top core and the unified memory model. It replaces the separate instruction-memory path when the unified-memory build is selected.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, number of consecutive data grants with fetch pending before fetch is forced to win

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-low reset: 0 = reset asserted
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  one-cycle pulse, fetch request accepted by memory
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DW  fetched instruction word
- d_req  in  1  data request; held with payload until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  DW/8  byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  one-cycle pulse, data request accepted
- d_rvalid  out  1  one-cycle pulse, load data valid or store acknowledged
- d_rdata  out  DW  load data; 0 for stores
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write strobe
- mem_be  out  DW/8  byte enables
- mem_addr  out  AW  address
- mem_wdata  out  DW  write data
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  memory response (every transaction, reads and writes)
- mem_rdata  in  DW  read data
- proto_err  out  1  sticky: mem_rvalid seen outside WAIT_RSP

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; starve_cnt=0; owner=none.
  - All outputs are 0: mem_* buses, gnt, rvalid, rdata, proto_err.
  - Reset mid-transaction discards the outstanding response. A late mem_rvalid after reset release sets proto_err.
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE:
  - Samples if_req/d_req at the rising edge.
  - Winner rule:
    - Only d_req → data.
    - Only if_req → fetch.
    - Both → data, unless starve_cnt==STARVE_MAX, then fetch.
  - Winner payload is latched into the mem_* registers and owner is recorded; the FSM goes to REQ.
  - Fetch payload: we=0, be=all ones, wdata=0.
  - No request → stay in IDLE.
- REQ:
  - mem_req=1; mem_* stay stable.
  - When mem_ready=1, the owner's gnt pulses in that same cycle (combinational from mem_ready & state REQ & owner). The FSM goes to WAIT_RSP and mem_req deasserts at the edge.
- WAIT_RSP:
  - When mem_rvalid=1, the owner's rvalid=1 and rdata=mem_rdata in the same cycle (combinational). The FSM goes to IDLE.
  - The other port's rvalid stays 0, and its rdata holds 0.
- Latency: minimum 3 cycles from request sample to response (IDLE → REQ → WAIT_RSP). There is a 1-cycle IDLE bubble between back-to-back transactions.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when data wins while if_req=1.
  - Clears when fetch wins or if_req=0 at arbitration.
- Requesters must hold req and payload until gnt. Deasserting early is illegal. The arbiter uses only the payload latched at arbitration.
- mem_rvalid in IDLE or REQ is ignored for routing and sets proto_err. Only reset clears proto_err.
- Address/data pass through unmodified; no alignment checks.

Decomposition:
- Shared package mem_bus_pkg:
  - state enum: IDLE, REQ, WAIT_RSP
  - owner enum: OWN_NONE, OWN_IF, OWN_D
  - AW/DW defaults
  - be-all-ones constant
- One natural sub-module: starve_counter (saturating counter with clear/increment, width $clog2(STARVE_MAX+1)). Everything else stays flat.

Test Plan:
- Reset: drive rst=0 mid-REQ with if_req=1, if_addr=0x10 → all outputs 0 immediately and state IDLE. After release, a stray mem_rvalid → proto_err=1.
- Single fetch, if_addr=0x0000_0004, mem_ready=1 in REQ, mem_rvalid 2 cycles later with mem_rdata=0x0040_0093:
  - mem_req/mem_addr=0x4 on cycle 1
  - if_gnt pulse on cycle 1
  - if_rvalid with if_rdata=0x0040_0093
  - d_rvalid stays 0
- Store, d_addr=0x100, d_be=4'b0011, d_wdata=0xDEAD_BEEF, mem_ready delayed 3 cycles:
  - mem_* stable for all 3 REQ cycles
  - d_gnt pulses once
  - d_rvalid pulses with d_rdata=0
- Simultaneous requests (if_req and d_req both high) → data granted first, fetch granted next arbitration.
- Starvation: d_req and if_req held continuously, STARVE_MAX=4 → grant order D,D,D,D,IF,D…, then the counter clears.
- Memory stall: mem_rvalid withheld 10 cycles in WAIT_RSP with new d_req asserted → no new mem_req and no gnt until the response arrives.
